mul_sequencer: RTL and testbench

Multi-cycle shift-add multiply sequencer for the multicycle ARM core. It replaces the single-cycle MUL/UMULL/SMULL paths of the 32-bit ALU with a 32-iteration datapath. The main control FSM issues a one-cycle `start` and stalls on `busy` until `done`, then writes `result_lo`/`result_hi` to the register file and latches `flags` when S is set.

---
 rtl/mul_sequencer.sv | 137 +++++++++++++
 tb/tb_mul_sequencer.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mul_sequencer.sv
// Multi-cycle shift-add multiplier for MUL/UMULL/SMULL, one iteration per CALC cycle.
// Define MULSEQ_EARLY_TERM_EN to leave CALC as soon as the remaining multiplier is zero.
module mul_sequencer #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result_lo,
    output logic [WIDTH-1:0] result_hi,
    output logic [1:0]       flags
);

    localparam int unsigned CW = $clog2(WIDTH);
    localparam logic [1:0] OpMul   = 2'b00;
    localparam logic [1:0] OpSmull = 2'b10;

    typedef enum logic [1:0] {StIdle, StCalc, StFix, StDone} state_e;

    state_e               state_q, state_d;
    logic [1:0]           op_q, op_d;
    logic [WIDTH-1:0]     mcand_q, mcand_d;
    logic [WIDTH-1:0]     mplier_q, mplier_d;
    logic                 neg_q, neg_d;
    logic [2*WIDTH-1:0]   acc_q, acc_d;
    logic [CW-1:0]        count_q, count_d;
    logic [WIDTH-1:0]     result_lo_q, result_lo_d;
    logic [WIDTH-1:0]     result_hi_q, result_hi_d;
    logic [1:0]           flags_q, flags_d;

    logic                 smull;
    logic [2*WIDTH-1:0]   addend;
    logic [2*WIDTH-1:0]   product;

    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        mcand_d     = mcand_q;
        mplier_d    = mplier_q;
        neg_d       = neg_q;
        acc_d       = acc_q;
        count_d     = count_q;
        result_lo_d = result_lo_q;
        result_hi_d = result_hi_q;
        flags_d     = flags_q;

        smull   = (op == OpSmull);
        addend  = {{WIDTH{1'b0}}, mcand_q} << count_q;
        product = neg_q ? -acc_q : acc_q;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    // SMULL works on magnitudes; the sign is reapplied in FIX
                    op_d     = op;
                    mcand_d  = (smull && a[WIDTH-1]) ? -a : a;
                    mplier_d = (smull && b[WIDTH-1]) ? -b : b;
                    neg_d    = smull && (a[WIDTH-1] ^ b[WIDTH-1]);
                    acc_d    = '0;
                    count_d  = '0;
                    state_d  = StCalc;
                end
            end
            StCalc: begin
                if (mplier_q[0]) begin
                    acc_d = acc_q + addend;
                end
                mplier_d = mplier_q >> 1;
                count_d  = count_q + CW'(1);
`ifdef MULSEQ_EARLY_TERM_EN
                if (count_q == CW'(WIDTH - 1) || mplier_d == '0) begin
                    state_d = StFix;
                end
`else
                if (count_q == CW'(WIDTH - 1)) begin
                    state_d = StFix;
                end
`endif
            end
            StFix: begin
                result_lo_d = product[WIDTH-1:0];
                if (op_q == OpMul) begin
                    result_hi_d = '0;
                    flags_d     = {product[WIDTH-1], product[WIDTH-1:0] == '0};
                end else begin
                    result_hi_d = product[2*WIDTH-1:WIDTH];
                    flags_d     = {product[2*WIDTH-1], product == '0};
                end
                state_d = StDone;
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= StIdle;
            op_q        <= '0;
            mcand_q     <= '0;
            mplier_q    <= '0;
            neg_q       <= 1'b0;
            acc_q       <= '0;
            count_q     <= '0;
            result_lo_q <= '0;
            result_hi_q <= '0;
            flags_q     <= '0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            mcand_q     <= mcand_d;
            mplier_q    <= mplier_d;
            neg_q       <= neg_d;
            acc_q       <= acc_d;
            count_q     <= count_d;
            result_lo_q <= result_lo_d;
            result_hi_q <= result_hi_d;
            flags_q     <= flags_d;
        end
    end

    assign busy      = (state_q != StIdle);
    assign done      = (state_q == StDone);
    assign result_lo = result_lo_q;
    assign result_hi = result_hi_q;
    assign flags     = flags_q;

endmodule

// File: tb/tb_mul_sequencer.sv
// Self-checking bench for mul_sequencer: arithmetic reference model checked every cycle,
// directed literal cases, then randomized start/operand/reset traffic.
module tb_mul_sequencer;

`ifdef MULSEQ_EARLY_TERM_EN
    localparam bit EARLY = 1'b1;
`else
    localparam bit EARLY = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [1:0]  op = 2'b00;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic        busy;
    logic        done;
    logic [31:0] result_lo;
    logic [31:0] result_hi;
    logic [1:0]  flags;

    int total = 0;
    int bad = 0;
    int n_done = 0;

    mul_sequencer #(.WIDTH(32)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .op        (op),
        .a         (a),
        .b         (b),
        .busy      (busy),
        .done      (done),
        .result_lo (result_lo),
        .result_hi (result_hi),
        .flags     (flags)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: plain 64-bit arithmetic product plus latency from the multiplier's top bit
    function automatic void model(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                                  output logic [31:0] lo, output logic [31:0] hi,
                                  output logic [1:0] fl, output int lat);
        longint      sx, sy;
        logic [63:0] p;
        logic [31:0] eb;
        int          top;
        if (o == 2'b10) begin
            sx = longint'($signed(x));
            sy = longint'($signed(y));
            p  = sx * sy;
            eb = y[31] ? -y : y;
        end else begin
            p  = {32'b0, x} * {32'b0, y};
            eb = y;
        end
        lo = p[31:0];
        hi = (o == 2'b00) ? 32'b0 : p[63:32];
        fl = (o == 2'b00) ? {p[31], p[31:0] == 32'b0} : {p[63], p == 64'b0};
        top = 0;
        for (int i = 0; i < 32; i++) if (eb[i]) top = i;
        lat = EARLY ? top + 3 : 34;
    endfunction

    // Model state: cycle index 1 is the cycle after the accepting edge; done in cycle m_lat
    logic        m_active = 1'b0;
    int          m_cyc = 0;
    int          m_lat = 0;
    logic [31:0] m_lo = '0, m_hi = '0, p_lo = '0, p_hi = '0;
    logic [1:0]  m_fl = '0, p_fl = '0;
    logic        exp_done;

    always @(posedge clk) begin
        if (reset) begin
            m_active = 1'b0;
            m_lo = '0;
            m_hi = '0;
            m_fl = '0;
        end else if (m_active) begin
            m_cyc++;
            if (m_cyc > m_lat) begin
                m_active = 1'b0;
            end else if (m_cyc == m_lat) begin
                m_lo = p_lo;
                m_hi = p_hi;
                m_fl = p_fl;
            end
        end else if (start) begin
            m_active = 1'b1;
            m_cyc = 1;
            model(op, a, b, p_lo, p_hi, p_fl, m_lat);
        end
        #1;
        exp_done = m_active && (m_cyc == m_lat);
        if (exp_done) n_done++;
        check("cyc_busy", {63'b0, busy}, {63'b0, m_active});
        check("cyc_done", {63'b0, done}, {63'b0, exp_done});
        check("cyc_lo", {32'b0, result_lo}, {32'b0, m_lo});
        check("cyc_hi", {32'b0, result_hi}, {32'b0, m_hi});
        check("cyc_flags", {62'b0, flags}, {62'b0, m_fl});
    end

    task automatic run_op(input string name, input logic [1:0] o, input logic [31:0] x,
                          input logic [31:0] y, input logic [31:0] ehi, input logic [31:0] elo,
                          input logic [1:0] efl, input int lat_fixed, input int lat_early);
        logic [31:0] mlo, mhi;
        logic [1:0]  mfl;
        int          mlat, got, lat_exp;
        lat_exp = EARLY ? lat_early : lat_fixed;
        model(o, x, y, mlo, mhi, mfl, mlat);
        check({name, "_model_lo"}, {32'b0, mlo}, {32'b0, elo});
        check({name, "_model_hi"}, {32'b0, mhi}, {32'b0, ehi});
        check({name, "_model_flags"}, {62'b0, mfl}, {62'b0, efl});
        check({name, "_model_lat"}, 64'(mlat), 64'(lat_exp));
        @(negedge clk);
        start = 1'b1;
        op = o;
        a = x;
        b = y;
        @(negedge clk);
        start = 1'b0;
        a = $urandom;
        b = $urandom;
        op = 2'($urandom);
        got = 0;
        for (int i = 1; i <= 40; i++) begin
            if (done) begin
                got = i;
                break;
            end
            @(negedge clk);
        end
        check({name, "_latency"}, 64'(got), 64'(lat_exp));
        check({name, "_lo"}, {32'b0, result_lo}, {32'b0, elo});
        check({name, "_hi"}, {32'b0, result_hi}, {32'b0, ehi});
        check({name, "_flags"}, {62'b0, flags}, {62'b0, efl});
        @(negedge clk);
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 7))
            0: return 32'h0;
            1: return 32'h1;
            2: return 32'h8000_0000;
            3: return 32'hFFFF_FFFF;
            4: return 32'($urandom_range(0, 255));
            5: return -32'($urandom_range(1, 255));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        int nd;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        check("reset_busy", {63'b0, busy}, 64'd0);
        check("reset_done", {63'b0, done}, 64'd0);
        check("reset_lo", {32'b0, result_lo}, 64'd0);
        check("reset_hi", {32'b0, result_hi}, 64'd0);
        check("reset_flags", {62'b0, flags}, 64'd0);

        run_op("umull_max", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001,
               2'b10, 34, 34);
        run_op("smull_neg", 2'b10, 32'hFFFF_FFFE, 32'h0000_0003, 32'hFFFF_FFFF, 32'hFFFF_FFFA,
               2'b10, 34, 4);
        run_op("smull_min", 2'b10, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0,
               2'b00, 34, 34);
        run_op("mul_wrap", 2'b00, 32'h0001_0000, 32'h0001_0000, 32'h0, 32'h0, 2'b01, 34, 19);
        run_op("mul_small", 2'b00, 32'd7, 32'd6, 32'h0, 32'd42, 2'b00, 34, 5);
        run_op("umull_b0", 2'b01, 32'h0000_1234, 32'h0, 32'h0, 32'h0, 2'b01, 34, 3);
        run_op("umull_b5", 2'b01, 32'd3, 32'd5, 32'h0, 32'd15, 2'b00, 34, 5);
        run_op("rsv_op", 2'b11, 32'h8000_0000, 32'h0000_0002, 32'h1, 32'h0, 2'b00, 34, 4);

        // start held high with operands churning while busy: only the first op completes
        @(negedge clk);
        start = 1'b1;
        op = 2'b01;
        a = 32'h1234_5678;
        b = 32'd9;
        nd = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done) begin
                nd++;
                start = 1'b0;
                break;
            end
            start = 1'b1;
            a = $urandom;
            b = $urandom;
            op = 2'($urandom);
        end
        check("ignore_lo", {32'b0, result_lo}, 64'hA3D7_0A38);
        check("ignore_hi", {32'b0, result_hi}, 64'h0);
        check("ignore_flags", {62'b0, flags}, 64'h0);
        repeat (3) begin
            @(negedge clk);
            if (done) nd++;
        end
        check("ignore_done_count", 64'(nd), 64'd1);
        check("ignore_idle", {63'b0, busy}, 64'd0);

        // reset during CALC iteration 10
        @(negedge clk);
        start = 1'b1;
        op = 2'b01;
        a = $urandom | 32'h1;
        b = 32'h8000_0001;
        @(negedge clk);
        start = 1'b0;
        repeat (9) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("abort_busy", {63'b0, busy}, 64'd0);
        check("abort_done", {63'b0, done}, 64'd0);
        check("abort_lo", {32'b0, result_lo}, 64'd0);
        check("abort_hi", {32'b0, result_hi}, 64'd0);
        check("abort_flags", {62'b0, flags}, 64'd0);
        nd = 0;
        repeat (30) begin
            @(negedge clk);
            if (done) nd++;
        end
        check("abort_no_done", 64'(nd), 64'd0);
        run_op("after_abort", 2'b00, 32'd7, 32'd6, 32'h0, 32'd42, 2'b00, 34, 5);

        // random traffic; the per-cycle compare process does the checking
        nd = n_done;
        for (int i = 0; i < 20000; i++) begin
            @(negedge clk);
            start = $urandom_range(0, 1) == 1;
            reset = $urandom_range(0, 1999) == 0;
            op = 2'($urandom);
            a = pick();
            b = pick();
        end
        @(negedge clk);
        start = 1'b0;
        reset = 1'b0;
        repeat (40) @(negedge clk);
        check("random_ops_completed", 64'(n_done - nd > 200), 64'd1);
        check("final_idle", {63'b0, busy}, 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
